// File: rtl/inst_loader.sv
// Instruction loader: accepts decoded field tuples, packs each into a 20-bit
// instruction word and writes it to consecutive instruction-memory addresses.
module inst_loader #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [14:0]       in_bamt,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [19:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned WORD_W = 20;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr_cnt, addr_cnt_n;
    logic [CNT_W-1:0]    count_n;
    logic                err_n;
    logic                we_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [WORD_W-1:0]   wdata_n;
    logic                at_top;

    // Field packing by opcode class: R-type, load, store, jump/branch.
    function automatic logic [WORD_W-1:0] encode(
        input logic [4:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [14:0] bamt
    );
        logic [WORD_W-1:0] word;
        if ((op < 5'd7) || (op == 5'd11)) begin
            word = {op, rd, rs, rt};
        end else if (op == 5'd12) begin
            word = {op, rd, rt, rs};
        end else if (op == 5'd13) begin
            word = {op, rs, rd, 5'b0};
        end else begin
            word = {op, bamt};
        end
        return word;
    endfunction

    assign at_top = (addr_cnt == {ADDR_W{1'b1}});

    // Next-state, counters and write-port payload.
    always_comb begin
        state_n    = state;
        addr_cnt_n = addr_cnt;
        count_n    = count;
        err_n      = err;
        we_n       = 1'b0;
        addr_n     = imem_addr;
        wdata_n    = imem_wdata;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = RUN;
                    addr_cnt_n = base_addr;
                    count_n    = '0;
                    err_n      = 1'b0;
                end
            end
            RUN: begin
                if (in_valid) begin
                    we_n    = 1'b1;
                    addr_n  = addr_cnt;
                    wdata_n = encode(in_op, in_rd, in_rs, in_rt, in_bamt);
                    count_n = count + CNT_W'(1);
                    // The counter saturates at the top address rather than wrapping.
                    if (!at_top) begin
                        addr_cnt_n = addr_cnt + ADDR_W'(1);
                    end
                    if (in_last) begin
                        state_n = DRAIN;
                    end else if (at_top) begin
                        err_n   = 1'b1;
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            count      <= '0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            addr_cnt   <= addr_cnt_n;
            count      <= count_n;
            err        <= err_n;
            imem_we    <= we_n;
            imem_addr  <= addr_n;
            imem_wdata <= wdata_n;
            in_ready   <= (state_n == RUN);
            busy       <= (state_n != IDLE);
            done       <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Bench for inst_loader: session-level reference model with a per-cycle
// comparator, directed sessions with literal expectations, then random traffic.
module tb_inst_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned TOP    = 255;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_op = '0, in_rd = '0, in_rs = '0, in_rt = '0;
    logic [14:0]       in_bamt = '0;
    logic              in_last = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [19:0]       imem_wdata;
    logic              busy, done, err;
    logic [ADDR_W:0]   count;

    inst_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
        .in_rs(in_rs), .in_rt(in_rt), .in_bamt(in_bamt), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int done_seen = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [19:0]       data;
        int unsigned       at;
    } wr_t;
    wr_t log_q[$];

    // Session model: "accepting" while tuples are taken, "tail" counts the
    // cycles left after the session's final acceptance.
    bit                m_accepting;
    int                m_tail;
    int unsigned       m_addr;
    bit                e_we, e_done, e_err;
    logic [ADDR_W-1:0] e_addr;
    logic [19:0]       e_wdata;
    int unsigned       e_count;

    function automatic logic [19:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [14:0] bamt);
        case (int'(op))
            0, 1, 2, 3, 4, 5, 6, 11: return {op, rd, rs, rt};
            12:                      return {op, rd, rt, rs};
            13:                      return {op, rs, rd, 5'd0};
            default:                 return {op, bamt};
        endcase
    endfunction

    task automatic model_reset();
        m_accepting = 1'b0;
        m_tail      = 0;
        m_addr      = 0;
        e_we        = 1'b0;
        e_done      = 1'b0;
        e_err       = 1'b0;
        e_addr      = '0;
        e_wdata     = '0;
        e_count     = 0;
    endtask

    task automatic model_step();
        bit was_idle;
        bit acc;
        if (!rst_n) return;
        was_idle = !m_accepting && (m_tail == 0);
        acc      = m_accepting && in_valid;
        e_we     = acc;
        if (acc) begin
            e_addr  = ADDR_W'(m_addr);
            e_wdata = enc(in_op, in_rd, in_rs, in_rt, in_bamt);
            e_count = e_count + 1;
            if (in_last || m_addr == TOP) begin
                if (!in_last) e_err = 1'b1;
                m_accepting = 1'b0;
                m_tail      = 2;
            end
            if (m_addr < TOP) m_addr = m_addr + 1;
        end else if (m_tail > 0) begin
            m_tail = m_tail - 1;
        end
        if (was_idle && start) begin
            m_accepting = 1'b1;
            m_addr      = int'(base_addr);
            e_count     = 0;
            e_err       = 1'b0;
        end
        e_done = (m_tail == 1);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparator; outputs are stable around the falling edge.
    initial begin
        #2;
        forever begin
            @(negedge clk);
            cyc++;
            chk("in_ready",   32'(in_ready),   32'(m_accepting));
            chk("busy",       32'(busy),       32'(m_accepting || m_tail > 0));
            chk("done",       32'(done),       32'(e_done));
            chk("err",        32'(err),        32'(e_err));
            chk("count",      32'(count),      e_count);
            chk("imem_we",    32'(imem_we),    32'(e_we));
            chk("imem_addr",  32'(imem_addr),  32'(e_addr));
            chk("imem_wdata", 32'(imem_wdata), 32'(e_wdata));
            if (imem_we === 1'b1) log_q.push_back('{imem_addr, imem_wdata, cyc});
            if (done === 1'b1) done_seen++;
        end
    end

    task automatic drive(input logic s, input logic [ADDR_W-1:0] b, input logic v,
                         input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [14:0] bamt, input logic last);
        @(negedge clk);
        #1;
        start = s; base_addr = b; in_valid = v; in_op = op; in_rd = rd;
        in_rs = rs; in_rt = rt; in_bamt = bamt; in_last = last;
        @(posedge clk);
        model_step();
    endtask

    task automatic begin_session(input logic [ADDR_W-1:0] b);
        drive(1'b1, b, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 15'd0, 1'b0);
    endtask

    task automatic tup(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [14:0] bamt, input logic last);
        drive(1'b0, 8'h00, 1'b1, op, rd, rs, rt, bamt, last);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 15'd0, 1'b0);
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #1;
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1;
        model_reset();
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        model_step();
    endtask

    task automatic chk_write(input string name, input int idx,
                             input logic [ADDR_W-1:0] addr, input logic [19:0] data);
        if (idx >= log_q.size()) begin
            chk({name, "_present"}, 32'(log_q.size()), 32'(idx + 1));
        end else begin
            chk({name, "_addr"}, 32'(log_q[idx].addr), 32'(addr));
            chk({name, "_data"}, 32'(log_q[idx].data), 32'(data));
        end
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Reference encoder pinned to hand-packed words.
        chk("enc_r",  32'(enc(5'd3, 5'd1, 5'd2, 5'd4, 15'd0)), 32'h18444);
        chk("enc_j",  32'(enc(5'd20, 5'd0, 5'd0, 5'd0, 15'h1234)), 32'hA1234);

        // Single R-type tuple.
        log_q.delete(); done_seen = 0;
        begin_session(8'h10);
        tup(5'd3, 5'd1, 5'd2, 5'd4, 15'd0, 1'b1);
        idle(4);
        chk("s1_writes", 32'(log_q.size()), 32'd1);
        chk_write("s1_w0", 0, 8'h10, 20'h18444);
        chk("s1_count", 32'(count), 32'd1);
        chk("s1_done", 32'(done_seen), 32'd1);

        // Load, store, jump, op 11 back-to-back.
        log_q.delete(); done_seen = 0;
        begin_session(8'h20);
        tup(5'd12, 5'd5, 5'd7, 5'd6, 15'd0, 1'b0);
        tup(5'd13, 5'd3, 5'd9, 5'd31, 15'h7FFF, 1'b0);
        tup(5'd20, 5'd31, 5'd31, 5'd31, 15'h1234, 1'b0);
        tup(5'd11, 5'd1, 5'd2, 5'd4, 15'h7FFF, 1'b1);
        idle(4);
        chk_write("s2_load",  0, 8'h20, 20'h614C7);
        chk_write("s2_store", 1, 8'h21, 20'h6A460);
        chk_write("s2_jump",  2, 8'h22, 20'hA1234);
        chk_write("s2_op11",  3, 8'h23, 20'h58444);
        chk("s2_count", 32'(count), 32'd4);
        chk("s2_err", 32'(err), 32'd0);
        if (log_q.size() == 4) chk("s2_b2b", log_q[3].at - log_q[0].at, 32'd3);

        // Four consecutive writes from base 0.
        log_q.delete(); done_seen = 0;
        begin_session(8'h00);
        for (int i = 0; i < 4; i++) tup(5'(i), 5'd1, 5'd1, 5'd1, 15'd0, 1'(i == 3));
        idle(4);
        chk("s3_writes", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            chk("s3_addr", 32'(log_q[i].addr), 32'(i));
        chk("s3_count", 32'(count), 32'd4);
        chk("s3_err", 32'(err), 32'd0);

        // Address space exhausted without last.
        log_q.delete(); done_seen = 0;
        begin_session(8'hFE);
        for (int i = 0; i < 3; i++) tup(5'd1, 5'd2, 5'd3, 5'd4, 15'd0, 1'b0);
        idle(4);
        chk("s4_writes", 32'(log_q.size()), 32'd2);
        chk_write("s4_w0", 0, 8'hFE, 20'h08864);
        chk_write("s4_w1", 1, 8'hFF, 20'h08864);
        chk("s4_err", 32'(err), 32'd1);
        chk("s4_done", 32'(done_seen), 32'd1);
        chk("s4_count", 32'(count), 32'd2);

        // Reset right after an acceptance drops the session.
        log_q.delete(); done_seen = 0;
        begin_session(8'h40);
        tup(5'd2, 5'd1, 5'd1, 5'd1, 15'd0, 1'b0);
        pulse_reset(3);
        idle(4);
        chk("s5_writes", 32'(log_q.size()), 32'd1);
        chk("s5_done", 32'(done_seen), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_err_cleared", 32'(err), 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset(int'($urandom_range(1, 3)));
            end else begin
                drive(1'($urandom_range(0, 7) == 0),
                      $urandom_range(0, 1) ? 8'($urandom_range(8'hF8, 8'hFF)) : 8'($urandom),
                      1'($urandom_range(0, 3) != 0),
                      5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                      15'($urandom), 1'($urandom_range(0, 5) == 0));
            end
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
